// File: rtl/uart_rx_if.sv
// uart_rx_if: CPU data-bus slave signals of the UART receiver.
//   wb_dbus_adr/dat/sel/we/cyc : bus request, driven by the CPU (master)
//   rdt                        : read data, non-zero only while ack is high
//   ack                        : one-cycle acknowledge from the receiver (slave)
interface uart_rx_if;
    logic [31:0] wb_dbus_adr;
    logic [31:0] wb_dbus_dat;
    logic [3:0]  wb_dbus_sel;
    logic        wb_dbus_we;
    logic        wb_dbus_cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (
        output wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
        input  rdt, ack
    );

    modport slave (
        input  wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
        output rdt, ack
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: bus-mapped 8N1 UART receiver with 16x oversampling and a byte FIFO.
// Ports:
//   wb_clk  : clock
//   wb_rst  : asynchronous active-high reset
//   bus     : data-bus slave (adr bit 2: 0 = DATA, 1 = STATUS)
//   baud_en : one-cycle strobe at 16x the bit rate
//   rx      : serial input, asynchronous, idles high
//   ready   : receive FIFO not empty
// STATUS: bit0 ready, bit1 full, bit2 overrun (W1C), bit3 frame_err (W1C).
module uart_rx #(
    parameter int                AWIDTH = 8,
    parameter logic [AWIDTH-1:0] ADDR   = 8'h50,
    parameter int                DEPTH  = 4
) (
    input  logic     wb_clk,
    input  logic     wb_rst,
    uart_rx_if.slave bus,
    input  logic     baud_en,
    input  logic     rx,
    output logic     ready
);
    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_r;
    logic [1:0]  sync_r;
    logic        armed_r;
    logic [3:0]  tick_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic [7:0]  mem_r [DEPTH];
    logic [PW:0] wptr_r;
    logic [PW:0] rptr_r;
    logic        ready_r;
    logic        overrun_r;
    logic        frame_err_r;
    logic        ack_r;
    logic [31:0] rdt_r;
    logic        pop_pend_r;

    logic        rxs_s;
    logic        stop_sample_s;
    logic        push_req_s;
    logic        frame_set_s;
    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic        do_push_s;
    logic        ovr_set_s;
    logic [PW:0] wptr_nxt_s;
    logic [PW:0] rptr_nxt_s;
    logic        match_s;
    logic        ack_next_s;
    logic        is_stat_s;
    logic        rd_s;
    logic        clr_s;
    logic [31:0] rd_val_s;
    logic        unused_s;

    assign rxs_s         = sync_r[1];
    assign stop_sample_s = (state_r == STOP) && baud_en && (tick_r == 4'd15);
    assign push_req_s    = stop_sample_s && rxs_s;
    assign frame_set_s   = stop_sample_s && !rxs_s;

    assign empty_s = (wptr_r == rptr_r);
    assign full_s  = (wptr_r[PW] != rptr_r[PW]) && (wptr_r[PW-1:0] == rptr_r[PW-1:0]);
    // The pop was decided when ack rose; it lands on the edge where ack falls.
    assign pop_s      = pop_pend_r && !empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push_s  = push_req_s && (!full_s || pop_s);
    assign ovr_set_s  = push_req_s && full_s && !pop_s;
    assign wptr_nxt_s = do_push_s ? (wptr_r + PTR_ONE) : wptr_r;
    assign rptr_nxt_s = pop_s ? (rptr_r + PTR_ONE) : rptr_r;

    assign match_s    = (bus.wb_dbus_adr[31:32-AWIDTH] == ADDR);
    assign ack_next_s = bus.wb_dbus_cyc && match_s && !ack_r;
    assign is_stat_s  = bus.wb_dbus_adr[2];
    assign rd_s       = ack_next_s && !bus.wb_dbus_we;
    assign clr_s      = ack_next_s && bus.wb_dbus_we && bus.wb_dbus_sel[0] && is_stat_s;

    // Two-flop synchroniser for the asynchronous rx pin (idle level 1).
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx};
        end
    end

    // Receive FSM: start detect, mid-bit sampling, byte assembly, stop check.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_r   <= IDLE;
            armed_r   <= 1'b0;
            tick_r    <= 4'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Only a high-to-low transition starts a frame; a held-low
                    // line after a stop-bit error must go high first.
                    if (baud_en && armed_r && !rxs_s) begin
                        state_r <= START;
                        tick_r  <= 4'd0;
                    end else if (rxs_s) begin
                        armed_r <= 1'b1;
                    end
                end
                START: begin
                    if (baud_en) begin
                        if (tick_r == 4'd7) begin
                            tick_r    <= 4'd0;
                            bit_idx_r <= 3'd0;
                            state_r   <= rxs_s ? IDLE : DATA;
                        end else begin
                            tick_r <= tick_r + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (baud_en) begin
                        tick_r <= tick_r + 4'd1;
                        if (tick_r == 4'd15) begin
                            shift_r   <= {rxs_s, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                            if (bit_idx_r == 3'd7) begin
                                state_r <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (baud_en) begin
                        tick_r <= tick_r + 4'd1;
                        if (tick_r == 4'd15) begin
                            state_r <= IDLE;
                            armed_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    armed_r <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; contents are meaningless until the pointers say otherwise.
    always_ff @(posedge wb_clk) begin
        if (do_push_s) begin
            mem_r[wptr_r[PW-1:0]] <= shift_r;
        end
    end

    // FIFO pointers and the registered not-empty output.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            ready_r <= 1'b0;
        end else begin
            wptr_r  <= wptr_nxt_s;
            rptr_r  <= rptr_nxt_s;
            ready_r <= (wptr_nxt_s != rptr_nxt_s);
        end
    end

    // Sticky error flags, write-1-to-clear; a new event beats a clear.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            overrun_r   <= ovr_set_s   || (overrun_r   && !(clr_s && bus.wb_dbus_dat[2]));
            frame_err_r <= frame_set_s || (frame_err_r && !(clr_s && bus.wb_dbus_dat[3]));
        end
    end

    // Read-data mux, sampled on the edge that raises ack.
    always_comb begin
        rd_val_s = 32'd0;
        if (is_stat_s) begin
            rd_val_s = {28'd0, frame_err_r, overrun_r, full_s, !empty_s};
        end else if (!empty_s) begin
            rd_val_s = {24'd0, mem_r[rptr_r[PW-1:0]]};
        end else begin
            rd_val_s = 32'd0;
        end
    end

    // Bus response: single-cycle ack, rdt valid only with ack, pop scheduling.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            ack_r      <= 1'b0;
            rdt_r      <= 32'd0;
            pop_pend_r <= 1'b0;
        end else begin
            ack_r      <= ack_next_s;
            rdt_r      <= rd_s ? rd_val_s : 32'd0;
            pop_pend_r <= rd_s && !is_stat_s && !empty_s;
        end
    end

    assign bus.ack = ack_r;
    assign bus.rdt = rdt_r;
    assign ready   = ready_r;

    assign unused_s = ^{bus.wb_dbus_adr[31-AWIDTH:3], bus.wb_dbus_adr[1:0],
                        bus.wb_dbus_dat[31:4], bus.wb_dbus_dat[1:0],
                        bus.wb_dbus_sel[3:1]};
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (DEPTH = 4, baud_en = 1,
// 16 clocks per bit). Frame vectors come from a table; overrun, false start,
// break, read/push race and reset mid-frame are hand-written sequences.
module tb_uart_rx;
    localparam logic [31:0] A_DATA = 32'h5000_0000;
    localparam logic [31:0] A_STAT = 32'h5000_0004;
    localparam logic [31:0] A_NONE = 32'h6000_0000;

    logic wb_clk = 1'b0;
    logic wb_rst;
    logic baud_en;
    logic rx;
    logic ready;

    uart_rx_if bus();

    uart_rx #(.AWIDTH(8), .ADDR(8'h50), .DEPTH(4)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .bus    (bus),
        .baud_en(baud_en),
        .rx     (rx),
        .ready  (ready)
    );

    always #5 wb_clk = ~wb_clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic rdy_hist [160];
    logic race_ack;
    logic [31:0] race_rdt;
    logic prev_ack = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [31:0] exp_stat;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // rdt must be 0 whenever ack is low; ack never high two cycles running.
    always @(negedge wb_clk) begin
        if (!wb_rst) begin
            n_checks++;
            if ((!bus.ack && bus.rdt !== 32'd0) || (bus.ack && prev_ack)) begin
                n_fail++;
                $display("FAIL bus_hygiene: ack=%b prev_ack=%b rdt=%08h, expected rdt=0 without ack and no back-to-back ack",
                         bus.ack, prev_ack, bus.rdt);
            end
        end
        prev_ack <= bus.ack;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    // Drives one frame; negedge j precedes edge N+j. rdy_hist[k] = ready after N+k.
    // If rd_at >= 0 a DATA read is issued at negedge rd_at and its ack/rdt captured.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_at);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int j = 0; j < 160; j++) begin
            @(negedge wb_clk);
            if (j > 0) rdy_hist[j-1] = ready;
            if (j == rd_at + 1) begin
                race_ack = bus.ack;
                race_rdt = bus.rdt;
                bus.wb_dbus_cyc = 1'b0;
            end
            if (j == rd_at) begin
                bus.wb_dbus_adr = A_DATA;
                bus.wb_dbus_we  = 1'b0;
                bus.wb_dbus_sel = 4'hF;
                bus.wb_dbus_cyc = 1'b1;
            end
            rx = bits[j/16];
        end
    endtask

    task automatic bus_xfer(input logic [31:0] a, input logic we, input logic [31:0] dv,
                            input logic [3:0] s, output logic [31:0] d, output int lat);
        @(negedge wb_clk);
        bus.wb_dbus_adr = a;
        bus.wb_dbus_we  = we;
        bus.wb_dbus_dat = dv;
        bus.wb_dbus_sel = s;
        bus.wb_dbus_cyc = 1'b1;
        lat = -1;
        d   = 32'd0;
        for (int k = 1; k <= 4 && lat < 0; k++) begin
            @(negedge wb_clk);
            if (bus.ack) begin
                lat = k;
                d   = bus.rdt;
            end
        end
        bus.wb_dbus_cyc = 1'b0;
        bus.wb_dbus_we  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int          lat;
        bus_xfer(a, 1'b0, 32'd0, 4'hF, d, lat);
        check({name, " ack_latency"}, 32'(lat), 32'd1);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] dv, input logic [3:0] s);
        logic [31:0] d;
        int          lat;
        bus_xfer(a, 1'b1, dv, s, d, lat);
        check("write ack_latency", 32'(lat), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        logic [31:0] exp_seq [5];

        vecs[0] = '{8'h55, 1'b1, 32'h1, 32'h55};
        vecs[1] = '{8'hA3, 1'b0, 32'h8, 32'h0};
        vecs[2] = '{8'h00, 1'b1, 32'h1, 32'h00};
        vecs[3] = '{8'hFF, 1'b1, 32'h1, 32'hFF};
        vecs[4] = '{8'h80, 1'b1, 32'h1, 32'h80};
        vecs[5] = '{8'h3C, 1'b1, 32'h1, 32'h3C};
        exp_seq = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h00};

        wb_rst  = 1'b1;
        baud_en = 1'b1;
        rx      = 1'b1;
        bus.wb_dbus_adr = 32'd0;
        bus.wb_dbus_dat = 32'd0;
        bus.wb_dbus_sel = 4'd0;
        bus.wb_dbus_we  = 1'b0;
        bus.wb_dbus_cyc = 1'b0;
        idle(3);
        check("reset ack", {31'd0, bus.ack}, 32'd0);
        check("reset rdt", bus.rdt, 32'd0);
        check("reset ready", {31'd0, ready}, 32'd0);
        wb_rst = 1'b0;
        idle(5);
        rd_chk("status after reset", A_STAT, 32'h0);

        // Bus hygiene: unmapped address and DATA read while empty.
        bus_xfer(A_NONE, 1'b0, 32'd0, 4'hF, d, lat);
        check("unmapped no_ack", 32'(lat), 32'hFFFF_FFFF);
        check("unmapped rdt", d, 32'd0);
        rd_chk("data read empty", A_DATA, 32'h0);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, -1);
            rx = 1'b1;
            idle(4);
            check("ready before push", {31'd0, rdy_hist[153]}, 32'd0);
            check("ready after push", {31'd0, rdy_hist[154]}, {31'd0, vecs[i].stop});
            rd_chk("vec status", A_STAT, vecs[i].exp_stat);
            rd_chk("vec data", A_DATA, vecs[i].exp_data);
            wr(A_STAT, 32'hC, 4'hF);
            rd_chk("vec status cleared", A_STAT, 32'h0);
        end

        // False start: 4 low clocks only.
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(200);
        check("false start ready", {31'd0, ready}, 32'd0);
        rd_chk("false start status", A_STAT, 32'h0);

        // Framing error followed by a break, then a clean frame.
        send_frame(8'hA3, 1'b0, -1);
        idle(60);
        rx = 1'b1;
        idle(10);
        rd_chk("frame_err status", A_STAT, 32'h8);
        wr(A_STAT, 32'h8, 4'hE);
        rd_chk("sel0 clear ignored", A_STAT, 32'h8);
        wr(A_STAT, 32'h8, 4'hF);
        rd_chk("frame_err cleared", A_STAT, 32'h0);
        send_frame(8'h5A, 1'b1, -1);
        idle(4);
        wr(A_DATA, 32'hFF, 4'hF);
        rd_chk("after break status", A_STAT, 32'h1);
        rd_chk("after break data", A_DATA, 32'h5A);

        // Overrun: five frames into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, -1);
        end
        idle(4);
        rd_chk("overrun status", A_STAT, 32'h7);
        @(negedge wb_clk);
        bus.wb_dbus_adr = A_DATA;
        bus.wb_dbus_we  = 1'b0;
        bus.wb_dbus_sel = 4'hF;
        bus.wb_dbus_cyc = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge wb_clk);
            check("held cyc ack", {31'd0, bus.ack}, {31'd0, k[0]});
            if (k[0]) check("held cyc data", bus.rdt, exp_seq[(k-1)/2]);
        end
        bus.wb_dbus_cyc = 1'b0;
        rd_chk("overrun sticky", A_STAT, 32'h4);
        wr(A_STAT, 32'h4, 4'hF);
        rd_chk("overrun cleared", A_STAT, 32'h0);

        // Read acked on the same edge as a push into an empty FIFO.
        idle(4);
        send_frame(8'h96, 1'b1, 154);
        idle(4);
        check("race ack", {31'd0, race_ack}, 32'd1);
        check("race rdt", race_rdt, 32'd0);
        rd_chk("race status", A_STAT, 32'h1);
        rd_chk("race data", A_DATA, 32'h96);

        // Reset in the middle of a frame with two bytes queued.
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        idle(4);
        rd_chk("queued status", A_STAT, 32'h3 & 32'h1);
        rx = 1'b0;
        idle(62);
        wb_rst = 1'b1;
        #1;
        check("mid-frame reset ready", {31'd0, ready}, 32'd0);
        check("mid-frame reset ack", {31'd0, bus.ack}, 32'd0);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        rx = 1'b1;
        rd_chk("post reset status", A_STAT, 32'h0);
        idle(20);
        send_frame(8'hC3, 1'b1, -1);
        idle(4);
        rd_chk("C3 status", A_STAT, 32'h1);
        rd_chk("C3 data", A_DATA, 32'hC3);
        rd_chk("C3 drained", A_STAT, 32'h0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
